// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out receiver with valid/ready word output
// Optional PARITY_CHECK_EN macro adds an even-parity bit after each data word.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             overrun,
  output logic             perr
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    count;
  logic             last_bit;
  logic             complete;
  logic             accept_word;
`ifdef PARITY_CHECK_EN
  logic             word_perr;
  logic             perr_q;
`endif

  always_comb begin
    sr_shift   = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
    last_bit   = (count == CW'(WIDTH - 1));
    state_next = state;
    complete   = 1'b0;
    word       = sr_shift;
`ifdef PARITY_CHECK_EN
    word_perr  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        if (en && last_bit) begin
`ifdef PARITY_CHECK_EN
          state_next = PAR;
`else
          state_next = IDLE;
          complete   = 1'b1;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        // Data word is already fully shifted in; this strobe carries only the parity bit.
        if (en) begin
          state_next = IDLE;
          complete   = 1'b1;
          word       = sr;
          word_perr  = (^sr) ^ sin;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign accept_word = complete && (!q_valid || q_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sr      <= '0;
      count   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        sr    <= '0;
        count <= '0;
      end
      if (state == SHIFT && en) begin
        sr    <= sr_shift;
        count <= last_bit ? '0 : count + CW'(1);
      end
      if (accept_word) begin
        q       <= word;
        q_valid <= 1'b1;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // perr travels with q: loaded only when the word is taken, dropped on handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perr_q <= 1'b0;
    end else if (accept_word) begin
      perr_q <= word_perr;
    end else if (!complete && q_valid && q_ready) begin
      perr_q <= 1'b0;
    end
  end
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - randomized + directed bench for sipo_deserializer against a frame-level model
// Runs both bit orders side by side; honours PARITY_CHECK_EN if defined.
module tb_sipo_deserializer;

`ifdef PARITY_CHECK_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       en = 1'b0;
  logic       sin = 1'b0;
  logic       q_ready = 1'b0;
  logic [7:0] q_m, q_l;
  logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, perr_m, perr_l;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .en(en), .sin(sin),
    .q(q_m), .q_valid(valid_m), .q_ready(q_ready),
    .busy(busy_m), .overrun(ovr_m), .perr(perr_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .en(en), .sin(sin),
    .q(q_l), .q_valid(valid_l), .q_ready(q_ready),
    .busy(busy_l), .overrun(ovr_l), .perr(perr_l)
  );

  // Model: a frame is a list of received bits; the word is assembled from that list.
  logic       m_active = 1'b0;
  int         m_n = 0;
  logic [8:0] m_bits = '0;
  logic [7:0] exp_q_m = '0, exp_q_l = '0;
  logic       exp_valid = 1'b0, exp_ovr = 1'b0, exp_perr = 1'b0;
  logic       m_done;
  logic [8:0] m_full;
  logic       m_perr;

  function automatic logic [7:0] word_of(input logic [8:0] f, input bit msb);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) begin
      if (msb) w[7 - i] = f[i];
      else     w[i]     = f[i];
    end
    return w;
  endfunction

  assign m_done = m_active && en && (m_n == FRAME - 1);
  assign m_full = m_bits | (9'(sin) << (FRAME - 1));
`ifdef PARITY_CHECK_EN
  assign m_perr = (^m_full[7:0]) ^ m_full[8];
`else
  assign m_perr = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rst) begin
      m_active  <= 1'b0;
      m_n       <= 0;
      m_bits    <= '0;
      exp_q_m   <= '0;
      exp_q_l   <= '0;
      exp_valid <= 1'b0;
      exp_ovr   <= 1'b0;
      exp_perr  <= 1'b0;
    end else begin
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1;
          m_n      <= 0;
          m_bits   <= '0;
        end
      end else if (en) begin
        if (m_done) begin
          m_active <= 1'b0;
          m_n      <= 0;
        end else begin
          m_bits[m_n] <= sin;
          m_n         <= m_n + 1;
        end
      end
      if (m_done) begin
        if (!exp_valid || q_ready) begin
          exp_q_m   <= word_of(m_full, 1'b1);
          exp_q_l   <= word_of(m_full, 1'b0);
          exp_valid <= 1'b1;
          exp_perr  <= m_perr;
        end else begin
          exp_ovr <= 1'b1;
        end
      end else if (exp_valid && q_ready) begin
        exp_valid <= 1'b0;
        exp_perr  <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("q_msb", 32'(q_m), 32'(exp_q_m));
      check("q_lsb", 32'(q_l), 32'(exp_q_l));
      check("valid_msb", 32'(valid_m), 32'(exp_valid));
      check("valid_lsb", 32'(valid_l), 32'(exp_valid));
      check("busy_msb", 32'(busy_m), 32'(m_active));
      check("busy_lsb", 32'(busy_l), 32'(m_active));
      check("overrun_msb", 32'(ovr_m), 32'(exp_ovr));
      check("overrun_lsb", 32'(ovr_l), 32'(exp_ovr));
      check("perr_msb", 32'(perr_m), 32'(exp_perr));
      check("perr_lsb", 32'(perr_l), 32'(exp_perr));
    end
  end

  task automatic step(input logic s, input logic e, input logic b, input logic r);
    start   = s;
    en      = e;
    sin     = b;
    q_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Bits go out w[7] first; q_ready is raised only on the completing strobe.
  task automatic send_frame(input logic [7:0] w, input bit gaps, input logic rdy_last, input logic pbit);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (gaps) step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
      step(1'b0, 1'b1, w[7 - i], (FRAME == 8 && i == 7) ? rdy_last : 1'b0);
    end
`ifdef PARITY_CHECK_EN
    if (gaps) step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
    step(1'b0, 1'b1, pbit, rdy_last);
`else
    if (pbit) step(1'b0, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_on = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Reset mid-frame, then a clean frame
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_q", 32'(q_m), 32'd0);
    rst = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check("a5_q", 32'(q_m), 32'hA5);
    check("a5_model_q", 32'(exp_q_m), 32'hA5);
    check("a5_valid", 32'(valid_m), 32'd1);
    check("a5_busy", 32'(busy_m), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("accept_valid", 32'(valid_m), 32'd0);
    check("accept_q_hold", 32'(q_m), 32'hA5);

    // Gapped strobes
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("gap_q", 32'(q_m), 32'hA5);
    check("gap_valid", 32'(valid_m), 32'd1);

    // Overrun while A5 pending
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ovr_q", 32'(q_m), 32'hA5);
    check("ovr_flag", 32'(ovr_m), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_accept_valid", 32'(valid_m), 32'd0);
    check("ovr_sticky", 32'(ovr_m), 32'd1);

    // Handshake on the completion cycle replaces the word
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check("swap_q", 32'(q_m), 32'h3C);
    check("swap_valid", 32'(valid_m), 32'd1);
    check("swap_ovr", 32'(ovr_m), 32'd0);

    // LSB-first ordering
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check("lsb_a5", 32'(q_l), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC0, 1'b0, 1'b0, 1'b0);
    check("lsb_03", 32'(q_l), 32'h03);
    check("msb_c0", 32'(q_m), 32'hC0);
    check("model_lsb_03", 32'(exp_q_l), 32'h03);

`ifdef PARITY_CHECK_EN
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    check("par_ok", 32'(perr_m), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("par_bad", 32'(perr_m), 32'd1);
    check("model_par_bad", 32'(exp_perr), 32'd1);
`endif

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(199) != 0);
      step(1'($urandom_range(7) == 0), 1'($urandom_range(9) < 7),
           1'($urandom_range(1)), 1'($urandom_range(2) == 0));
    end
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
